param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits, ≥1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, ≥2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when occupancy ≥ AF_LEVEL, range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when occupancy ≤ AE_LEVEL, range 0..DEPTH-1.
REQ-005 SHALL have a localparam AW = $clog2(DEPTH) for pointer width and a count width of AW+1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  synchronous clear of FIFO state; memory contents are not cleared.
REQ-009 inp_val  input  1  producer has data_in valid.
REQ-010 inp_rdy  output  1  FIFO can accept a word.
REQ-011 data_in  input  WIDTH  write payload.
REQ-012 out_val  output  1  data_out holds the oldest stored word.
REQ-013 out_rdy  input  1  consumer accepts data_out.
REQ-014 data_out  output  WIDTH  head-of-queue payload, first-word-fall-through.
REQ-015 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-016 almost_full  output  1  count ≥ AF_LEVEL.
REQ-017 almost_empty  output  1  count ≤ AE_LEVEL.
REQ-018 high_water  output  AW+1  maximum count reached since the last reset or flush.

Function
REQ-019 push SHALL be defined as inp_val && inp_rdy, and pop as out_val && out_rdy, both sampled in the same cycle.
REQ-020 inp_rdy SHALL equal (count != DEPTH) and out_val SHALL equal (count != 0), both combinational from registered count, with no dependence on inp_val or out_rdy.
REQ-021 On push, mem[wr_ptr] SHALL be written with data_in and wr_ptr SHALL increment modulo DEPTH.
REQ-022 On pop, rd_ptr SHALL increment modulo DEPTH.
REQ-023 data_out SHALL be mem[rd_ptr], read combinationally; a word pushed at edge N is visible with out_val=1 in the cycle after edge N, so empty-to-output latency is 1 cycle, with no same-cycle bypass.
REQ-024 count SHALL update in a single process: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-025 When full, push SHALL be impossible; a pop in that cycle SHALL complete, and inp_rdy SHALL rise the following cycle.
REQ-026 When empty, pop SHALL be impossible; a push in that cycle SHALL complete, and out_val SHALL rise the following cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 without a gap or corruption of order.
REQ-028 almost_full and almost_empty SHALL be registered-equivalent, i.e. derived combinationally from registered count only.
REQ-029 high_water SHALL update at each edge to max(high_water, next count).
REQ-030 flush=1 SHALL set wr_ptr, rd_ptr, count and high_water to 0 at the edge, overriding any push or pop in that cycle, and the words offered in that cycle SHALL be discarded.
REQ-031 Data order SHALL be strictly first-in first-out, with no duplication or loss except by flush or reset.

Reset
REQ-032 rst=1 SHALL, at the edge, set wr_ptr=0, rd_ptr=0, count=0 and high_water=0, and SHALL take priority over flush, push and pop.
REQ-033 After reset, outputs SHALL be inp_rdy=1, out_val=0, almost_full=0, almost_empty=1 and high_water=0; data_out is don't-care while out_val=0.
REQ-034 Reset asserted mid-transfer SHALL abandon all stored words; no stale word SHALL appear with out_val=1 afterwards.

Verification
REQ-035 Fill/drain (WIDTH=8, DEPTH=4): push 0xA1,0xA2,0xA3,0xA4 with out_rdy=0 -> inp_rdy=0, count=4, almost_full=1; then out_rdy=1 -> data_out 0xA1..0xA4 in order, count returns to 0.
REQ-036 Full with simultaneous push and pop: count=4, inp_val=1, out_rdy=1 -> only the pop occurs, count=3; next cycle inp_rdy=1 and the push is accepted, count=4.
REQ-037 Wrap: continuous push and pop of 0..19 through DEPTH=4 with random out_rdy -> output sequence 0..19 exactly, and count never exceeds 4.
REQ-038 Flush: with 3 words stored, assert flush together with inp_val=1 -> next cycle count=0, out_val=0, high_water=0, and the flushed-cycle word never appears at the output.
REQ-039 Reset mid-operation: with 2 words stored and high_water=3, assert rst -> count=0, high_water=0, inp_rdy=1, out_val=0, almost_empty=1.
REQ-040 Thresholds (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2): step count 0→16→0 -> almost_empty=1 exactly for count ≤2 and almost_full=1 exactly for count ≥14, and high_water=16 at the end.

Source files
------------

// File: rtl/param_fifo.sv
// param_fifo: synchronous first-word-fall-through FIFO with occupancy,
// almost-full/almost-empty flags and a high-water mark.
// Storage is a register array read combinationally at rd_ptr; control state
// (pointers, count, high_water) is the only state touched by rst and flush.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        inp_val,
  output logic                        inp_rdy,
  input  logic [WIDTH-1:0]            data_in,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [WIDTH-1:0]            data_out,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      high_water
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Larger of the running high-water mark and the upcoming occupancy.
  function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    max_cnt = (a > b) ? a : b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    hw_q;
  logic             push;
  logic             pop;

  // Handshake flags come only from registered occupancy, never from the
  // partner's valid/ready, so no combinational path crosses the FIFO.
  assign inp_rdy      = (count_q != CW'(DEPTH));
  assign out_val      = (count_q != '0);
  assign push         = inp_val && inp_rdy;
  assign pop          = out_val && out_rdy;

  assign data_out     = mem[rd_ptr];
  assign count        = count_q;
  assign high_water   = hw_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Control state: reset beats flush, flush beats any push/pop that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hw_q    <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hw_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      hw_q    <= max_cnt(hw_q, count_nxt);
    end
  end

  // Payload storage; a word offered during reset or flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= data_in;
  end

endmodule
